// File: rtl/program_counter_pkg.sv
// Datapath-wide constants for the single-cycle LEGv8 core: address width,
// instruction size and reset vector.
package program_counter_pkg;

   localparam int unsigned PC_WIDTH       = 64;
   localparam int unsigned PC_INSTR_BYTES = 4;
   localparam logic [63:0] PC_RESET_VEC   = 64'h0;

endpackage

// File: rtl/pc_next_logic.sv
// Next-PC selection: sequential fetch or the branch target from the upstream adder.
// Purely combinational; the target is passed through verbatim, with no alignment masking.
module pc_next_logic
   import program_counter_pkg::*;
#(
   parameter int unsigned WIDTH       = PC_WIDTH,
   parameter int unsigned INSTR_BYTES = PC_INSTR_BYTES
) (
   input  logic [WIDTH-1:0] pc,
   input  logic [WIDTH-1:0] br_address,
   input  logic             branch,
   input  logic             uncond_branch,
   input  logic             z_flag,
   output logic             take_branch,
   output logic [WIDTH-1:0] pc_next
);

   always_comb begin
      take_branch = uncond_branch | (branch & z_flag);
      // The sequential add wraps modulo 2^WIDTH, with no overflow flag.
      pc_next     = take_branch ? br_address : pc + WIDTH'(INSTR_BYTES);
   end

endmodule

// File: rtl/program_counter.sv
// Program counter register of the single-cycle LEGv8 datapath; it drives the
// instruction-memory address and the branch adder.
module program_counter
   import program_counter_pkg::*;
#(
   parameter int unsigned      WIDTH       = PC_WIDTH,
   parameter int unsigned      INSTR_BYTES = PC_INSTR_BYTES,
   parameter logic [WIDTH-1:0] RESET_PC    = WIDTH'(PC_RESET_VEC)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             branch,
   input  logic             uncond_branch,
   input  logic             z_flag,
   input  logic [WIDTH-1:0] br_address,
   output logic [WIDTH-1:0] pc
);

   logic             take_branch;
   logic [WIDTH-1:0] pc_next;

   pc_next_logic #(
      .WIDTH       (WIDTH),
      .INSTR_BYTES (INSTR_BYTES)
   ) u_pc_next_logic (
      .pc            (pc),
      .br_address    (br_address),
      .branch        (branch),
      .uncond_branch (uncond_branch),
      .z_flag        (z_flag),
      .take_branch   (take_branch),
      .pc_next       (pc_next)
   );

   // A reset in the middle of a cycle discards any branch that was pending.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc <= RESET_PC;
      else        pc <= pc_next;
   end

   a_taken_loads_target: assert property (
      @(posedge clk) disable iff (!rst_n) take_branch |-> (pc_next == br_address));

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: directed scenarios plus random control
// and target patterns, with expectations from a small behavioural model.
module tb_program_counter;

   logic        clk;
   logic        rst_n;
   logic        branch;
   logic        uncond_branch;
   logic        z_flag;
   logic [63:0] br_address;
   logic [63:0] pc;

   logic [63:0] exp_q[$];
   logic [63:0] model_pc;
   int          checks;
   int          failures;

   program_counter dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .branch        (branch),
      .uncond_branch (uncond_branch),
      .z_flag        (z_flag),
      .br_address    (br_address),
      .pc            (pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, pending=%0d", exp_q.size());
      $fatal(1, "watchdog");
   end

   // Monitor: pc is presented after every rising edge.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         logic [63:0] e;
         e = exp_q.pop_front();
         checks++;
         if (pc !== e) begin
            failures++;
            $display("FAIL pc_after_edge: got=%h expected=%h t=%0t", pc, e, $time);
         end
      end
   end

   task automatic direct_check(input string name, input logic [63:0] e);
      checks++;
      if (pc !== e) begin
         failures++;
         $display("FAIL %s: got=%h expected=%h t=%0t", name, pc, e, $time);
      end
   endtask

   // Called just after a falling edge; returns at the next falling edge.
   task automatic drive(input logic b, input logic ub, input logic z,
                        input logic [63:0] addr, input logic [63:0] e);
      branch        = b;
      uncond_branch = ub;
      z_flag        = z;
      br_address    = addr;
      exp_q.push_back(e);
      model_pc = e;
      @(negedge clk);
   endtask

   function automatic logic [63:0] ref_next(input logic [63:0] cur, input logic b,
                                            input logic ub, input logic z,
                                            input logic [63:0] addr);
      if (ub || (b && z)) return addr;
      return cur + 64'd4;
   endfunction

   initial begin
      checks        = 0;
      failures      = 0;
      model_pc      = 64'h0;
      rst_n         = 1'b0;
      branch        = 1'b0;
      uncond_branch = 1'b1;
      z_flag        = 1'b0;
      br_address    = 64'h1234;
      #3;
      direct_check("reset_value", 64'h0);
      @(posedge clk);
      #1;
      direct_check("reset_held_over_edge", 64'h0);
      @(negedge clk);
      rst_n         = 1'b1;
      uncond_branch = 1'b0;

      for (int i = 1; i <= 10; i++)
         drive(1'b0, 1'b0, 1'b0, 64'h0, 64'(4 * i));

      drive(1'b1, 1'b0, 1'b0, 64'h2, 64'd44);
      for (int i = 0; i < 3; i++)
         drive(1'b0, 1'b1, 1'b0, 64'h2, 64'h2);
      drive(1'b0, 1'b0, 1'b1, 64'h100, 64'd6);
      drive(1'b0, 1'b0, 1'b1, 64'h100, 64'd10);
      drive(1'b0, 1'b0, 1'b1, 64'h100, 64'd14);

      drive(1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC);
      drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
      drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h4);
      for (int i = 2; i <= 11; i++)
         drive(1'b0, 1'b0, 1'b0, 64'h0, 64'(4 * i));

      // pc is 44 here: pulse reset between edges with an unconditional branch pending.
      branch        = 1'b0;
      uncond_branch = 1'b1;
      z_flag        = 1'b0;
      br_address    = 64'h2;
      #1 rst_n = 1'b0;
      #1 direct_check("async_reset_mid_cycle", 64'h0);
      #1 rst_n = 1'b1;
      #1 direct_check("reset_released_before_edge", 64'h0);
      exp_q.push_back(64'h2);
      model_pc = 64'h2;
      @(negedge clk);

      drive(1'b1, 1'b1, 1'b0, 64'h123, 64'h123);
      drive(1'b1, 1'b0, 1'b1, 64'h7, 64'h7);
      drive(1'b0, 1'b0, 1'b0, 64'h0, 64'hB);

      for (int i = 0; i < 300; i++) begin
         logic        b, ub, z;
         logic [63:0] addr;
         b    = 1'($urandom_range(0, 1));
         z    = 1'($urandom_range(0, 1));
         ub   = ($urandom_range(0, 3) == 0);
         addr = {$urandom, $urandom};
         if ($urandom_range(0, 7) == 0) addr = 64'hFFFF_FFFF_FFFF_FFF8;
         drive(b, ub, z, addr, ref_next(model_pc, b, ub, z, addr));
      end

      branch        = 1'b0;
      uncond_branch = 1'b0;
      z_flag        = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: pending=%0d expected=0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
